// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encodings and the sequential logic unit's FSM states.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational W-bit bitwise logic slice (AND/OR/XOR/NOR) used by the sequential logic unit.
module logic_slice
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: evaluates one CHUNK-bit slice per cycle, LSB first,
// with valid/ready handshakes on both sides and a registered zero flag.
module logic_unit_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero
);

    localparam int unsigned NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("logic_unit_seq: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_div
        $error("logic_unit_seq: CHUNK must divide WIDTH");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   f_q;
    logic               zero_q;

    logic               accept;
    logic               step;
    logic [31:0]        base;
    logic [CHUNK-1:0]   a_slice, b_slice, f_slice;

    assign base    = 32'(cnt_q) * 32'(CHUNK);
    assign a_slice = a_q[base +: CHUNK];
    assign b_slice = b_q[base +: CHUNK];

    logic_slice #(
        .W (CHUNK)
    ) u_slice (
        .a  (a_slice),
        .b  (b_slice),
        .op (op_q),
        .y  (f_slice)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are captured once so the ports may change freely while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_AND;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            f_q    <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (step) begin
            f_q[base +: CHUNK] <= f_slice;
            zero_q             <= zero_q & ~(|f_slice);
            // Counter parks on the last slice rather than wrapping.
            if (cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign f         = f_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: a 32/8 instance and a single-slice 8/8 instance.
module tb_logic_unit_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] a, b, f;
    logic [1:0]  op;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
    logic [7:0]  a8, b8, f8;
    logic [1:0]  op8;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] f;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    logic_unit_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .zero      (zero)
    );

    logic_unit_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .op        (op8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .f         (f8),
        .zero      (zero8)
    );

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic test_reset();
        int stray;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== 32'h0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: rdy=%b vld=%b f=%h z=%b want rdy=1 vld=0 f=0 z=0",
                     in_ready, out_valid, f, zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        a = 32'h0000_0F0F; b = 32'h5A5A_005A; op = OP_OR; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || f !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: vld=%b f=%h rdy=%b want vld=0 f=0 rdy=1",
                     out_valid, f, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL reset_no_stale: out_valid seen %0d cycles want 0", stray);
        end
    endtask

    task automatic test_ops();
        logic [31:0] ta [4] = '{32'h0000_0F0F, 32'hFFFF_0000, 32'h0000_0000, 32'h1234_5678};
        logic [31:0] tb [4] = '{32'h5A5A_005A, 32'h0000_FFFF, 32'h0000_0000, 32'h1234_5678};
        logic [1:0]  to [4] = '{OP_OR, OP_AND, OP_NOR, OP_XOR};
        logic [31:0] tf [4] = '{32'h5A5A_0F5F, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        logic        tz [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_t e;
        int lat;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{f: tf[i], zero: tz[i]});
            a = ta[i]; b = tb[i]; op = to[i]; in_valid = 1'b1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ops%0d_ready: in_ready=%b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = $urandom; b = $urandom; op = 2'($urandom);
            lat = 0;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            n_tests++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL ops%0d_latency: got %0d cycles want 4", i, lat);
            end
            e = sb.pop_front();
            n_tests++;
            if (f !== e.f || zero !== e.zero) begin
                n_fail++;
                $display("FAIL ops%0d_result: f=%h z=%b want f=%h z=%b", i, f, zero, e.f, e.zero);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ops%0d_release: vld=%b rdy=%b want vld=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        sb.push_back('{f: 32'h5A5A_0F5F, zero: 1'b0});
        a = 32'h0000_0F0F; b = 32'h5A5A_005A; op = OP_OR; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = $urandom; b = $urandom; op = OP_AND;
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== e.f || zero !== e.zero) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b f=%h z=%b want vld=1 rdy=0 f=%h z=%b",
                         i, out_valid, in_ready, f, zero, e.f, e.zero);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handshake: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        sb.push_back('{f: 32'h0000_0000, zero: 1'b1});
        a = 32'hFFFF_0000; b = 32'h0000_FFFF; op = OP_AND; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_accept: in_ready=%b want 0 (accepted)", in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        n_tests++;
        if (lat != 4 || f !== e.f || zero !== e.zero || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_next_result: lat=%0d f=%h z=%b want lat=4 f=%h z=%b",
                     lat, f, zero, e.f, e.zero);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, n_acc, last_acc;
        logic pre_acc, pre_val;
        exp_t e;
        cyc = 0; n_acc = 0; last_acc = -1;
        a = $urandom; b = $urandom; op = 2'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        while (cyc < 100 && (n_acc < 3 || sb.size() > 0)) begin
            pre_acc = in_ready & in_valid;
            pre_val = out_valid;
            if (pre_val === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected result f=%h", f);
                end else begin
                    e = sb.pop_front();
                    if (f !== e.f || zero !== e.zero) begin
                        n_fail++;
                        $display("FAIL b2b_result: f=%h z=%b want f=%h z=%b",
                                 f, zero, e.f, e.zero);
                    end
                end
            end
            if (pre_acc === 1'b1) begin
                sb.push_back('{f: model(a, b, op), zero: (model(a, b, op) == 32'h0)});
            end
            @(posedge clk); cyc++; #1;
            if (pre_acc === 1'b1) begin
                n_acc++;
                if (last_acc >= 0) begin
                    n_tests++;
                    if (cyc - last_acc != 6) begin
                        n_fail++;
                        $display("FAIL b2b_period: got %0d cycles want 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                if (n_acc == 3) begin
                    in_valid = 1'b0;
                end else begin
                    a = $urandom; b = $urandom; op = 2'($urandom);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (n_acc != 3 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_timeout: accepted %0d pending %0d want 3 and 0", n_acc, sb.size());
        end
    endtask

    task automatic test_narrow();
        logic [7:0] na [2] = '{8'h0F, 8'h3C};
        logic [7:0] nb [2] = '{8'h5A, 8'h3C};
        logic [1:0] no [2] = '{OP_OR, OP_XOR};
        logic [7:0] nf [2] = '{8'h5F, 8'h00};
        logic       nz [2] = '{1'b0, 1'b1};
        exp_t e;
        int lat;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{f: {24'h0, nf[i]}, zero: nz[i]});
            a8 = na[i]; b8 = nb[i]; op8 = no[i]; in_valid8 = 1'b1;
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            a8 = 8'hA5; b8 = 8'hC3; op8 = OP_NOR;
            lat = 0;
            while (out_valid8 !== 1'b1 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            e = sb.pop_front();
            n_tests++;
            if (lat != 1 || {24'h0, f8} !== e.f || zero8 !== e.zero) begin
                n_fail++;
                $display("FAIL narrow%0d: lat=%0d f=%h z=%b want lat=1 f=%h z=%b",
                         i, lat, f8, zero8, e.f[7:0], e.zero);
            end
            out_ready8 = 1'b1;
            @(posedge clk); #1;
            out_ready8 = 1'b0;
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = OP_AND;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = OP_AND;
        #1;
        test_reset();
        test_ops();
        test_backpressure();
        test_back_to_back();
        test_narrow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
